controller_packet_parser: RTL

CONTROLLER_PACKET_PARSER -- requirements
Module: controller_packet_parser

---
 rtl/controller_pkg.sv | 47 ++++
 rtl/byte_gap_timer.sv | 44 ++++
 rtl/controller_packet_parser.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : controller_pkg
//  Purpose  : Shared constants, state encoding and payload layout for the
//             controller packet parser.
//  Contents : HEADER_DEFAULT, PAYLOAD_LEN, STICK_CENTRE, payload slot indices,
//             parser state enum, idle (reset) payload helper.
//  Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_LEN    = 8;
  localparam int         IDX_W          = $clog2(PAYLOAD_LEN);
  localparam logic [7:0] STICK_CENTRE   = 8'h80;

  // Payload slot order, matching the byte order on the wire.
  localparam int SLOT_BTN_HI = 0;
  localparam int SLOT_BTN_LO = 1;
  localparam int SLOT_JOY_X  = 2;
  localparam int SLOT_JOY_Y  = 3;
  localparam int SLOT_C_X    = 4;
  localparam int SLOT_C_Y    = 5;
  localparam int SLOT_L_TRIG = 6;
  localparam int SLOT_R_TRIG = 7;

  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  // Idle controller: no buttons, sticks centred, triggers released.
  function automatic payload_t idle_payload();
    payload_t p;
    p              = '0;
    p[SLOT_JOY_X]  = STICK_CENTRE;
    p[SLOT_JOY_Y]  = STICK_CENTRE;
    p[SLOT_C_X]    = STICK_CENTRE;
    p[SLOT_C_Y]    = STICK_CENTRE;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_gap_timer
//  Purpose  : Counts clk cycles since the last kick while enabled; asserts
//             expired (combinational) in the cycle the silence reaches
//             TIMEOUT cycles.
//  Ports    : clk, reset (sync, active-high), enable, kick -> expired
//  Revision : 1.0 - initial release
// ============================================================================
module byte_gap_timer #(
  parameter int unsigned TIMEOUT = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds the number of silent cycles already elapsed, so the
  // TIMEOUT-th silent cycle is the one where it reads TIMEOUT-1.
  assign expired = enable && !kick && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable || kick || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/controller_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module   : controller_packet_parser
//  Purpose  : Parses HEADER + 8 payload bytes + XOR checksum frames from a
//             byte stream and commits good frames to the outputs on the next
//             vertical-blank frame_tick.
//  Ports    : clk, reset (sync, active-high)
//             rx_data[7:0], rx_valid   - received byte stream
//             frame_tick               - vertical blank pulse (commit point)
//             BUTTONS[15:0], JOY_X/JOY_Y/C_X/C_Y/L_TRIGGER/R_TRIGGER[7:0]
//                                      - committed controller state
//             frame_ok, frame_err      - one-cycle status pulses
//             err_count[7:0]           - saturating error counter
//  Revision : 1.0 - initial release
// ============================================================================
module controller_packet_parser
  import controller_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
  parameter int unsigned GAP_TIMEOUT = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_tick,
  output logic [15:0] BUTTONS,
  output logic [7:0]  JOY_X,
  output logic [7:0]  JOY_Y,
  output logic [7:0]  C_X,
  output logic [7:0]  C_Y,
  output logic [7:0]  L_TRIGGER,
  output logic [7:0]  R_TRIGGER,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  state_e           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [7:0]       xor_q,     xor_d;
  payload_t         stage_q,   stage_d;
  payload_t         commit_q,  commit_d;
  payload_t         out_q,     out_d;
  logic             pending_q, pending_d;
  logic             ok_q,      ok_d;
  logic             err_q,     err_d;
  logic [7:0]       errcnt_q,  errcnt_d;
  logic             gap_expired;

  byte_gap_timer #(
    .TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_q != ST_HUNT),
    .kick    (rx_valid),
    .expired (gap_expired)
  );

  // Frame reception FSM. A HEADER value is only special while hunting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    stage_d = stage_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (rx_valid && (rx_data == HEADER)) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          xor_d   = 8'h00;
        end
      end
      ST_PAYLOAD: begin
        if (gap_expired) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
        end else if (rx_valid) begin
          stage_d[idx_q] = rx_data;
          xor_d          = xor_q ^ rx_data;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (gap_expired) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
        end else if (rx_valid) begin
          ok_d    = (rx_data == xor_q);
          err_d   = (rx_data != xor_q);
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Commit path. The freshly validated frame is promoted from staging to the
  // commit source in the cycle frame_ok is high, so a tick in that same
  // cycle still commits only the previously pending frame. Staging cannot be
  // overwritten yet: at most a HEADER can arrive in that cycle.
  always_comb begin
    commit_d  = commit_q;
    out_d     = out_q;
    pending_d = pending_q;
    errcnt_d  = errcnt_q;
    if (frame_tick && pending_q) begin
      out_d     = commit_q;
      pending_d = 1'b0;
    end
    if (ok_q) begin
      commit_d  = stage_q;
      pending_d = 1'b1;
    end
    if (err_d && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      idx_q     <= '0;
      xor_q     <= 8'h00;
      stage_q   <= '0;
      commit_q  <= idle_payload();
      out_q     <= idle_payload();
      pending_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      errcnt_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      stage_q   <= stage_d;
      commit_q  <= commit_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign BUTTONS   = {out_q[SLOT_BTN_HI], out_q[SLOT_BTN_LO]};
  assign JOY_X     = out_q[SLOT_JOY_X];
  assign JOY_Y     = out_q[SLOT_JOY_Y];
  assign C_X       = out_q[SLOT_C_X];
  assign C_Y       = out_q[SLOT_C_Y];
  assign L_TRIGGER = out_q[SLOT_L_TRIG];
  assign R_TRIGGER = out_q[SLOT_R_TRIG];
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_count = errcnt_q;

endmodule
`default_nettype wire
